// File: rtl/cv32e40x_pkg.sv
// Shared types and defaults for the eXtension-interface result queue.
package cv32e40x_pkg;

  localparam int unsigned XIF_RQ_DEPTH  = 4;
  localparam int unsigned XIF_DATA_W    = 32;
  localparam int unsigned XIF_RD_W      = 5;

  // One queued result. The instruction ID is stored beside the entry because
  // its width is a parameter of the queue instance.
  typedef struct packed {
    logic [XIF_DATA_W-1:0] data;
    logic [XIF_RD_W-1:0]   rd;
    logic                  committed;
    logic                  killed;
  } xif_rq_entry_t;

endpackage

// File: rtl/cv32e40x_xif_result_queue.sv
// In-order result queue for offloaded instructions: results wait until the
// core commits (forward to the register file) or kills (silently dropped)
// their ID. Commits that arrive before the result are remembered per ID.
module cv32e40x_xif_result_queue
  import cv32e40x_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned DEPTH      = XIF_RQ_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [XIF_DATA_W-1:0]    in_data_i,
  input  logic [XIF_RD_W-1:0]      in_rd_i,
  input  logic [X_ID_WIDTH-1:0]    in_id_i,
  input  logic                     commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]    commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [XIF_DATA_W-1:0]    result_data_o,
  output logic [XIF_RD_W-1:0]      result_rd_o,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic                     result_we_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned N_ID  = 2 ** X_ID_WIDTH;

  xif_rq_entry_t                entry_q [DEPTH];
  xif_rq_entry_t                entry_d [DEPTH];
  logic [X_ID_WIDTH-1:0]        id_q    [DEPTH];
  logic [X_ID_WIDTH-1:0]        id_d    [DEPTH];
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [N_ID-1:0]              early_commit_q, early_commit_d;
  logic [N_ID-1:0]              early_kill_q, early_kill_d;

  xif_rq_entry_t                head;
  logic                         head_valid;
  logic                         head_drop;
  logic                         push;
  logic                         pop;
  logic [DEPTH-1:0]             match_vec;
  logic                         any_match;
  logic                         push_hits_commit;

  // Head view, handshake and commit matching.
  always_comb begin
    head           = entry_q[rd_ptr_q];
    head_valid     = valid_q[rd_ptr_q];
    result_valid_o = head_valid && head.committed && !head.killed;
    head_drop      = head_valid && head.killed;
    in_ready_o     = (count_q != CNT_W'(DEPTH));
    push           = in_valid_i && in_ready_o;
    pop            = (result_valid_o && result_ready_i) || head_drop;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (id_q[i] == commit_id_i);
    end
    any_match        = |match_vec;
    push_hits_commit = commit_valid_i && push && (in_id_i == commit_id_i);
  end

  assign result_data_o = head.data;
  assign result_rd_o   = head.rd;
  assign result_id_o   = id_q[rd_ptr_q];
  assign result_we_o   = result_valid_o;
  assign count_o       = count_q;

  // Next-state: commit marking, early-status table, push, pop/drop.
  always_comb begin
    entry_d        = entry_q;
    id_d           = id_q;
    valid_d        = valid_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    early_commit_d = early_commit_q;
    early_kill_d   = early_kill_q;

    // Mark queued entries; an entry that already has a status keeps it.
    if (commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (match_vec[i] && !entry_q[i].committed && !entry_q[i].killed) begin
          if (commit_kill_i) entry_d[i].killed    = 1'b1;
          else               entry_d[i].committed = 1'b1;
        end
      end
      if (!any_match && !push_hits_commit &&
          !early_commit_q[commit_id_i] && !early_kill_q[commit_id_i]) begin
        if (commit_kill_i) early_kill_d[commit_id_i]   = 1'b1;
        else               early_commit_d[commit_id_i] = 1'b1;
      end
    end

    // A pushed result absorbs any recorded or same-cycle status for its ID.
    if (push) begin
      entry_d[wr_ptr_q] = '{
        data:      in_data_i,
        rd:        in_rd_i,
        committed: early_commit_q[in_id_i] || (push_hits_commit && !commit_kill_i),
        killed:    early_kill_q[in_id_i]   || (push_hits_commit &&  commit_kill_i)
      };
      id_d[wr_ptr_q]          = in_id_i;
      valid_d[wr_ptr_q]       = 1'b1;
      early_commit_d[in_id_i] = 1'b0;
      early_kill_d[in_id_i]   = 1'b0;
      wr_ptr_d                = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers; reset discards every queued result and recorded status.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
        id_q[i]    <= '0;
      end
      valid_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      early_commit_q <= '0;
      early_kill_q   <= '0;
    end else begin
      entry_q        <= entry_d;
      id_q           <= id_d;
      valid_q        <= valid_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      early_commit_q <= early_commit_d;
      early_kill_q   <= early_kill_d;
    end
  end

endmodule
